// File: rtl/deserializer_if.sv
// Bus bundle between the serial source, the deserializer and the word consumer.
// The slave modport is the deserializer's view; master is the surrounding logic.
interface deserializer_if #(
  parameter int DATA_W = 16,
  localparam int MOD_W = $clog2(DATA_W)
);
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o
  );

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o
  );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel stage; one word per packet, with a bit-count code (0 = full word).
// Define DESERIALIZER_RIGHT_ALIGN_EN to LSB-align short words instead of MSB-aligning them.
module deserializer #(
  parameter int DATA_W = 16,
  localparam int MOD_W = $clog2(DATA_W)
) (
  input  logic           clk_i,
  input  logic           srst_i,
  deserializer_if.slave  bus
);

  localparam logic [MOD_W:0] CNT_FULL = DATA_W[MOD_W:0];
  localparam logic [MOD_W:0] CNT_LAST = CNT_FULL - 1'b1;

  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] shifted_in;
  logic [DATA_W-1:0] short_word;
  logic [MOD_W:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [MOD_W-1:0]  mod_reg, mod_next;
  logic              val_reg, val_next;

  always_comb begin
    shifted_in = {shift_reg[DATA_W-2:0], bus.ser_data_i};
`ifdef DESERIALIZER_RIGHT_ALIGN_EN
    // shift_reg is cleared at every emit, so bits above the k collected ones are already zero
    short_word = shift_reg;
`else
    short_word = shift_reg << (CNT_FULL - cnt_reg);
`endif

    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    mod_next   = mod_reg;
    val_next   = 1'b0;

    if (bus.ser_data_val_i) begin
      if (cnt_reg == CNT_LAST) begin
        data_next  = shifted_in;
        mod_next   = '0;
        val_next   = 1'b1;
        cnt_next   = '0;
        shift_next = '0;
      end else begin
        shift_next = shifted_in;
        cnt_next   = cnt_reg + 1'b1;
      end
    end else if (cnt_reg != '0) begin
      // first idle cycle after a partial packet terminates it
      data_next  = short_word;
      mod_next   = cnt_reg[MOD_W-1:0];
      val_next   = 1'b1;
      cnt_next   = '0;
      shift_next = '0;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      mod_reg   <= '0;
      val_reg   <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      mod_reg   <= mod_next;
      val_reg   <= val_next;
    end
  end

  assign bus.deser_data_o     = data_reg;
  assign bus.deser_data_mod_o = mod_reg;
  assign bus.deser_data_val_o = val_reg;

endmodule

// File: tb/tb_deserializer.sv
// Table-driven bench for deserializer with a scoreboard of expected words, codes and strobe cycles.
// Expected short-word alignment follows DESERIALIZER_RIGHT_ALIGN_EN.
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);
`ifdef DESERIALIZER_RIGHT_ALIGN_EN
  localparam bit RIGHT = 1'b1;
`else
  localparam bit RIGHT = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic srst_i = 1'b1;
  int   cyc    = 0;

  deserializer_if #(.DATA_W(DATA_W)) bus ();

  deserializer #(.DATA_W(DATA_W)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          len;
    logic [15:0] pat;
    int          gap;
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
    logic [3:0]  mod;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          cyc;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_data = '0;
  logic [3:0]  last_mod  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ser_data_i     = b;
    bus.ser_data_val_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Expected strobe edge: same edge as the last bit for a full word, one edge later for a short one.
  task automatic push_exp(input logic [15:0] data, input logic [3:0] mod, input int len);
    exp_t e;
    e.data = data;
    e.mod  = mod;
    e.cyc  = (len == DATA_W) ? cyc : cyc + 1;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (srst_i) begin
        last_data = '0;
        last_mod  = '0;
      end else if (bus.deser_data_val_o) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(bus.deser_data_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("word", 32'(bus.deser_data_o), 32'(e.data));
          check("mod", 32'(bus.deser_data_mod_o), 32'(e.mod));
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          $display("strobe: data=%h mod=%0d cycle=%0d", bus.deser_data_o, bus.deser_data_mod_o, cyc);
          last_data = e.data;
          last_mod  = e.mod;
        end
      end else begin
        check("hold_word", 32'(bus.deser_data_o), 32'(last_data));
        check("hold_mod", 32'(bus.deser_data_mod_o), 32'(last_mod));
      end
    end
  endtask

  initial begin
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;

    vecs[0]  = '{16, 16'hA5C3, 1, 16'hA5C3, 16'hA5C3, 4'd0};
    vecs[1]  = '{5,  16'h0016, 1, 16'hB000, 16'h0016, 4'd5};
    vecs[2]  = '{3,  16'h0007, 1, 16'hE000, 16'h0007, 4'd3};
    vecs[3]  = '{3,  16'h0001, 1, 16'h2000, 16'h0001, 4'd3};
    vecs[4]  = '{16, 16'h1234, 0, 16'h1234, 16'h1234, 4'd0};
    vecs[5]  = '{16, 16'hFFFF, 1, 16'hFFFF, 16'hFFFF, 4'd0};
    vecs[6]  = '{1,  16'h0001, 1, 16'h8000, 16'h0001, 4'd1};
    vecs[7]  = '{2,  16'h0002, 1, 16'h8000, 16'h0002, 4'd2};
    vecs[8]  = '{15, 16'h7ABC, 2, 16'hF578, 16'h7ABC, 4'd15};
    vecs[9]  = '{16, 16'h8001, 0, 16'h8001, 16'h8001, 4'd0};
    vecs[10] = '{4,  16'h000A, 1, 16'hA000, 16'h000A, 4'd4};
    vecs[11] = '{5,  16'h001F, 3, 16'hF800, 16'h001F, 4'd5};

    // Reset is asserted at time 0, before any clock edge.
    #1;
    check("reset_word", 32'(bus.deser_data_o), 32'h0);
    check("reset_mod", 32'(bus.deser_data_mod_o), 32'h0);
    check("reset_val", 32'(bus.deser_data_val_o), 32'h0);
    fork
      monitor();
    join_none
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    idle();
    idle();

    for (int i = 0; i < 12; i++) begin
      logic [15:0] p;
      p = vecs[i].pat;
      $display("vector %0d: len=%0d pattern=%h gap=%0d", i, vecs[i].len, p, vecs[i].gap);
      for (int b = vecs[i].len - 1; b >= 0; b--) send_bit(p[b]);
      push_exp(RIGHT ? vecs[i].exp_lsb : vecs[i].exp_msb, vecs[i].mod, vecs[i].len);
      for (int g = 0; g < vecs[i].gap; g++) idle();
    end

    // Reset between edges in the middle of a 7-bit packet: no strobe, outputs cleared at once.
    for (int b = 0; b < 7; b++) send_bit(1'b1);
    bus.ser_data_val_i = 1'b0;
    srst_i = 1'b1;
    #1;
    check("midreset_word", 32'(bus.deser_data_o), 32'h0);
    check("midreset_mod", 32'(bus.deser_data_mod_o), 32'h0);
    check("midreset_val", 32'(bus.deser_data_val_o), 32'h0);
    $display("mid-packet reset applied at cycle %0d", cyc);
    @(negedge clk_i);
    #1;
    srst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int b = 0; b < 3; b++) send_bit(1'b1);
    push_exp(RIGHT ? 16'h0007 : 16'hE000, 4'd3, 3);
    idle();
    idle();

    for (int t = 0; t < 20 && sb.size() != 0; t++) idle();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
